// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, issues one imem request at a time and feeds the IF/ID register.
// Optional build macro FETCH_PERF_CNT_EN adds saturating fetch/bubble counters.
module fetch_stage #(
    parameter int ADDR_W   = 32,
    parameter int PC_STEP  = 4,
    parameter int RESET_PC = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,
    input  logic              branch_taken,
    input  logic [ADDR_W-1:0] branch_target,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ready,
    input  logic [31:0]       imem_rdata,
    output logic [ADDR_W-1:0] pc_out,
    output logic [31:0]       instruction,
`ifdef FETCH_PERF_CNT_EN
    output logic [31:0]       fetch_count,
    output logic [31:0]       bubble_count,
`endif
    output logic              valid
);

    localparam logic [ADDR_W-1:0] STEP_C  = ADDR_W'(PC_STEP);
    localparam logic [ADDR_W-1:0] RST_PC_C = ADDR_W'(RESET_PC);

    typedef enum logic [1:0] {
        ST_BOOT  = 2'd0,
        ST_FETCH = 2'd1,
        ST_HOLD  = 2'd2
    } state_t;

    state_t            state_r;
    state_t            state_nxt_s;
    logic              req_r;
    logic              req_nxt_s;

    logic [ADDR_W-1:0] pc_r,       pc_nxt_s;
    logic [ADDR_W-1:0] pc_out_r,   pc_out_nxt_s;
    logic [31:0]       instr_r,    instr_nxt_s;
    logic              valid_r,    valid_nxt_s;
    logic              valid_ld_s;
    logic [ADDR_W-1:0] hold_pc_r,  hold_pc_nxt_s;
    logic [31:0]       hold_instr_r, hold_instr_nxt_s;
    logic              hold_full_r, hold_full_nxt_s;

    // State register; imem_req is registered alongside so it leaves a flop.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= ST_BOOT;
            req_r   <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            req_r   <= req_nxt_s;
        end
    end

    // Next-state logic; a redirect always lands in FETCH, even from BOOT or HOLD.
    always_comb begin
        state_nxt_s = state_r;
        if (branch_taken) begin
            state_nxt_s = ST_FETCH;
        end else begin
            case (state_r)
                ST_BOOT:  state_nxt_s = ST_FETCH;
                ST_FETCH: state_nxt_s = (imem_ready && stall) ? ST_HOLD : ST_FETCH;
                ST_HOLD:  state_nxt_s = stall ? ST_HOLD : ST_FETCH;
                default:  state_nxt_s = ST_BOOT;
            endcase
        end
    end

    // Output decode, computed one cycle early so the request comes straight from a flop.
    always_comb begin
        req_nxt_s = 1'b0;
        case (state_nxt_s)
            ST_FETCH: req_nxt_s = 1'b1;
            ST_BOOT:  req_nxt_s = 1'b0;
            ST_HOLD:  req_nxt_s = 1'b0;
            default:  req_nxt_s = 1'b0;
        endcase
    end

    // Datapath: PC advance, output capture, hold buffer and flush.
    always_comb begin
        pc_nxt_s         = pc_r;
        pc_out_nxt_s     = pc_out_r;
        instr_nxt_s      = instr_r;
        valid_nxt_s      = valid_r;
        valid_ld_s       = 1'b0;
        hold_pc_nxt_s    = hold_pc_r;
        hold_instr_nxt_s = hold_instr_r;
        hold_full_nxt_s  = hold_full_r;
        if (branch_taken) begin
            pc_nxt_s        = branch_target;
            instr_nxt_s     = 32'h0000_0000;
            valid_nxt_s     = 1'b0;
            valid_ld_s      = 1'b1;
            hold_full_nxt_s = 1'b0;
        end else begin
            case (state_r)
                ST_FETCH: begin
                    if (imem_ready) begin
                        pc_nxt_s = pc_r + STEP_C;
                        if (stall) begin
                            hold_pc_nxt_s    = pc_r;
                            hold_instr_nxt_s = imem_rdata;
                            hold_full_nxt_s  = 1'b1;
                        end else begin
                            pc_out_nxt_s = pc_r;
                            instr_nxt_s  = imem_rdata;
                            valid_nxt_s  = 1'b1;
                            valid_ld_s   = 1'b1;
                        end
                    end else if (!stall) begin
                        instr_nxt_s = 32'h0000_0000;
                        valid_nxt_s = 1'b0;
                        valid_ld_s  = 1'b1;
                    end else begin
                        valid_ld_s = 1'b0;
                    end
                end
                ST_HOLD: begin
                    if (!stall) begin
                        pc_out_nxt_s    = hold_pc_r;
                        instr_nxt_s     = hold_instr_r;
                        valid_nxt_s     = 1'b1;
                        valid_ld_s      = 1'b1;
                        hold_full_nxt_s = 1'b0;
                    end else begin
                        valid_ld_s = 1'b0;
                    end
                end
                ST_BOOT: valid_ld_s = 1'b0;
                default: valid_ld_s = 1'b0;
            endcase
        end
    end

    // Datapath registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc_r         <= RST_PC_C;
            pc_out_r     <= {ADDR_W{1'b0}};
            instr_r      <= 32'h0000_0000;
            valid_r      <= 1'b0;
            hold_pc_r    <= {ADDR_W{1'b0}};
            hold_instr_r <= 32'h0000_0000;
            hold_full_r  <= 1'b0;
        end else begin
            pc_r         <= pc_nxt_s;
            pc_out_r     <= pc_out_nxt_s;
            instr_r      <= instr_nxt_s;
            hold_pc_r    <= hold_pc_nxt_s;
            hold_instr_r <= hold_instr_nxt_s;
            hold_full_r  <= hold_full_nxt_s;
            if (valid_ld_s) begin
                valid_r <= valid_nxt_s;
            end else begin
                valid_r <= valid_r;
            end
        end
    end

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] fetch_cnt_r;
    logic [31:0] bubble_cnt_r;

    // Saturating event counters keyed on every load of the valid flag.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fetch_cnt_r  <= 32'd0;
            bubble_cnt_r <= 32'd0;
        end else begin
            if (valid_ld_s && valid_nxt_s && (fetch_cnt_r != 32'hFFFF_FFFF)) begin
                fetch_cnt_r <= fetch_cnt_r + 32'd1;
            end
            if (valid_ld_s && !valid_nxt_s && (state_r != ST_BOOT) &&
                (bubble_cnt_r != 32'hFFFF_FFFF)) begin
                bubble_cnt_r <= bubble_cnt_r + 32'd1;
            end
        end
    end

    assign fetch_count  = fetch_cnt_r;
    assign bubble_count = bubble_cnt_r;
`endif

    assign imem_req    = req_r;
    assign imem_addr   = pc_r;
    assign pc_out      = pc_out_r;
    assign instruction = instr_r;
    assign valid       = valid_r;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed + random bench for fetch_stage against a queue-based behavioural model.
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic [31:0] pc_out;
    logic [31:0] instruction;
    logic        valid;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] fetch_count;
    logic [31:0] bubble_count;
`endif

    always #5 clk = ~clk;

    fetch_stage #(.ADDR_W(32), .PC_STEP(4), .RESET_PC(0)) dut (
        .clk(clk), .rst(rst), .stall(stall),
        .branch_taken(branch_taken), .branch_target(branch_target),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ready(imem_ready), .imem_rdata(imem_rdata),
        .pc_out(pc_out), .instruction(instruction),
`ifdef FETCH_PERF_CNT_EN
        .fetch_count(fetch_count), .bubble_count(bubble_count),
`endif
        .valid(valid)
    );

    int n_cmp = 0;
    int n_err = 0;

    // Behavioural model: a pending-word queue stands in for the hold buffer.
    bit          booted;
    logic [31:0] m_pc, m_pc_out, m_instr;
    bit          m_valid;
    logic [63:0] hold_q[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        booted = 1'b0; m_pc = 32'h0; m_pc_out = 32'h0; m_instr = 32'h0; m_valid = 1'b0;
        hold_q.delete();
    endtask

    task automatic model_step(input bit s, input bit b, input logic [31:0] t,
                              input bit r, input logic [31:0] d);
        logic [63:0] e;
        if (b) begin
            m_pc = t; m_valid = 1'b0; m_instr = 32'h0; hold_q.delete(); booted = 1'b1;
        end else if (!booted) begin
            booted = 1'b1;
        end else if (hold_q.size() > 0) begin
            if (!s) begin
                e = hold_q.pop_front();
                m_pc_out = e[63:32]; m_instr = e[31:0]; m_valid = 1'b1;
            end
        end else if (r) begin
            if (!s) begin
                m_pc_out = m_pc; m_instr = d; m_valid = 1'b1;
            end else begin
                hold_q.push_back({m_pc, d});
            end
            m_pc = m_pc + 32'd4;
        end else if (!s) begin
            m_valid = 1'b0; m_instr = 32'h0;
        end
    endtask

    task automatic cycle(input bit s, input bit b, input logic [31:0] t,
                         input bit r, input logic [31:0] d);
        bit exp_req;
        stall = s; branch_taken = b; branch_target = t; imem_ready = r; imem_rdata = d;
        #1;
        exp_req = booted && (hold_q.size() == 0);
        chk("imem_req", {31'd0, imem_req}, {31'd0, exp_req});
        chk("imem_addr", imem_addr, m_pc);
        @(posedge clk);
        model_step(s, b, t, r, d);
        #1;
        chk("pc_out", pc_out, m_pc_out);
        chk("instruction", instruction, m_instr);
        chk("valid", {31'd0, valid}, {31'd0, m_valid});
        @(negedge clk);
    endtask

    initial begin
        logic [31:0] w8, wb;
        rst = 1'b0; stall = 1'b0; branch_taken = 1'b0; branch_target = 32'h0;
        imem_ready = 1'b1; imem_rdata = 32'hAFAF_AFAF;
        model_reset();
        #12;
        chk("rst_pc_out", pc_out, 32'h0);
        chk("rst_instr", instruction, 32'h0);
        chk("rst_valid", {31'd0, valid}, 32'd0);
        chk("rst_req", {31'd0, imem_req}, 32'd0);
        chk("rst_addr", imem_addr, 32'h0);
        @(negedge clk);
        rst = 1'b1;

        // Boot cycle, then the first fetch at PC 0.
        cycle(1'b0, 1'b0, 32'h0, 1'b1, 32'hAFAF_AFAF);
        cycle(1'b0, 1'b0, 32'h0, 1'b1, 32'hAFAF_AFAF);
        chk("tp_first_instr", instruction, 32'hAFAF_AFAF);
        chk("tp_first_pc", pc_out, 32'h0);
        chk("tp_next_addr", imem_addr, 32'h4);

        for (int i = 0; i < 3; i++) begin
            cycle(1'b0, 1'b0, 32'h0, 1'b1, $urandom);
            chk("tp_stream_pc", pc_out, 32'((i + 1) * 4));
            chk("tp_stream_valid", {31'd0, valid}, 32'd1);
        end

        // Stall with capture at PC 8.
        w8 = 32'h8888_0008;
        cycle(1'b0, 1'b1, 32'h8, 1'b1, 32'h1234_5678);
        cycle(1'b1, 1'b0, 32'h0, 1'b1, w8);
        cycle(1'b1, 1'b0, 32'h0, 1'b1, 32'h5555_5555);
        cycle(1'b0, 1'b0, 32'h0, 1'b1, 32'h6666_6666);
        chk("tp_release_pc", pc_out, 32'h8);
        chk("tp_release_instr", instruction, w8);
        chk("tp_release_addr", imem_addr, 32'hC);

        // Branch while holding a buffered word.
        wb = 32'hDEAD_0001;
        cycle(1'b1, 1'b0, 32'h0, 1'b1, wb);
        cycle(1'b1, 1'b1, 32'h40, 1'b1, 32'h7777_7777);
        chk("tp_flush_instr", instruction, 32'h0);
        chk("tp_flush_addr", imem_addr, 32'h40);
        for (int i = 0; i < 3; i++) begin
            cycle(1'b0, 1'b0, 32'h0, 1'b1, 32'h1000_0000 + 32'(i));
            chk("tp_buf_dropped", {31'd0, instruction !== wb}, 32'd1);
        end

        // PC wrap.
        cycle(1'b0, 1'b1, 32'hFFFF_FFFC, 1'b0, 32'h0);
        cycle(1'b0, 1'b0, 32'h0, 1'b1, 32'hCAFE_F00D);
        chk("tp_wrap_pc", pc_out, 32'hFFFF_FFFC);
        chk("tp_wrap_addr", imem_addr, 32'h0);

        for (int i = 0; i < 300; i++) begin
            cycle(($urandom % 4) == 0, ($urandom % 16) == 0, $urandom,
                  ($urandom % 4) != 0, $urandom);
        end

        // Asynchronous reset in the middle of a cycle.
        @(posedge clk);
        #3;
        rst = 1'b0;
        #1;
        chk("arst_pc_out", pc_out, 32'h0);
        chk("arst_instr", instruction, 32'h0);
        chk("arst_valid", {31'd0, valid}, 32'd0);
        chk("arst_req", {31'd0, imem_req}, 32'd0);
        chk("arst_addr", imem_addr, 32'h0);
        model_reset();
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 30; i++) begin
            cycle(($urandom % 4) == 0, ($urandom % 16) == 0, $urandom,
                  ($urandom % 4) != 0, $urandom);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
